// File: rtl/fix_pkg.sv
// Encodings shared with session_manager: message types, session states, validity codes,
// plus the scheduler's own state type and a legality helper.
package fix_pkg;

  typedef enum logic [3:0] {
    MSG_NONE       = 4'd0,
    MSG_LOGON      = 4'd1,
    MSG_HEARTBEAT  = 4'd2,
    MSG_RESEND_REQ = 4'd3,
    MSG_LOGOUT     = 4'd4,
    MSG_RESET      = 4'd5,
    MSG_GAP_FILL   = 4'd6,
    MSG_BUSINESS   = 4'd7
  } msg_type_e;

  typedef enum logic [2:0] {
    SESS_FREE,
    SESS_LOGON_SENT,
    SESS_ACTIVE,
    SESS_LOGOUT_SENT,
    SESS_CLOSED
  } sess_state_e;

  typedef enum logic [1:0] {
    VAL_OK,
    VAL_BAD_SEQ,
    VAL_BAD_TYPE,
    VAL_NO_SESSION
  } valid_code_e;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_OFFER,
    SCH_BUSY
  } sched_state_e;

  function automatic logic is_legal_type(input logic [3:0] t);
    return (t >= MSG_LOGON) && (t <= MSG_BUSINESS);
  endfunction

endpackage

// File: rtl/msg_req_fifo.sv
// Request FIFO with registered head and read-only view of every entry, so the
// scheduler can look for an already-queued heartbeat for the same host.
module msg_req_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [W-1:0]                push_data_i,
  input  logic                        pop_i,
  output logic [W-1:0]                head_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [DEPTH-1:0][W-1:0]     entries_o,
  output logic [DEPTH-1:0]            entry_live_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0]  head_q, head_d;
  logic [AW:0]   count;

  // NOTE: every signal written here gets a default before any condition, so no latch is inferred.
  always_comb begin
    wr_d   = wr_q + {{AW{1'b0}}, push_i};
    rd_d   = rd_q + {{AW{1'b0}}, pop_i};
    // Writing into an otherwise empty FIFO: the new word becomes the head directly.
    head_d = (push_i && (wr_q == rd_d)) ? push_data_i : mem_q[rd_d[AW-1:0]];
  end

  assign count   = wr_q - rd_q;
  assign count_o = count;
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = head_q;

  // Live means occupied and not leaving with this cycle's pop.
  always_comb begin
    logic [AW-1:0] off;
    off          = '0;
    entries_o    = '0;
    entry_live_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off             = AW'(i) - rd_q[AW-1:0];
      entries_o[i]    = mem_q[i];
      entry_live_o[i] = ({1'b0, off} < count) && !(pop_i && (off == '0));
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which words are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/msg_request_scheduler.sv
// Queues message requests from session_manager and offers them one at a time to the
// message creator; logout uses a priority slot, duplicate heartbeats are coalesced.
module msg_request_scheduler
  import fix_pkg::*;
#(
  parameter int HOST_W  = 10,
  parameter int DEPTH   = 8,
  parameter int DONE_TO = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  input  logic [3:0]                req_type_i,
  input  logic [HOST_W-1:0]         req_host_i,
  output logic                      msg_valid_o,
  output logic [3:0]                msg_type_o,
  output logic [HOST_W-1:0]         msg_host_o,
  input  logic                      msg_ready_i,
  input  logic                      creator_done_i,
  output logic [$clog2(DEPTH):0]    q_count_o,
  output logic                      overflow_o,
  output logic                      illegal_o,
  output logic                      done_timeout_o
);

  localparam int W  = 4 + HOST_W;
  localparam int TW = $clog2(DONE_TO);

  sched_state_e       state_q, state_d;
  logic               msg_valid_q, msg_valid_d;
  logic [3:0]         msg_type_q, msg_type_d;
  logic [HOST_W-1:0]  msg_host_q, msg_host_d;
  logic               from_slot_q, from_slot_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               slot_full_q, slot_full_d;
  logic [HOST_W-1:0]  slot_host_q, slot_host_d;
  logic               overflow_q, overflow_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]            fifo_head;
  logic [DEPTH-1:0][W-1:0] fifo_entries;
  logic [DEPTH-1:0]        fifo_live;
  logic                    accept, req_legal, req_logout, req_hb, hb_dup, queue_req;

  msg_req_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fifo_push),
    .push_data_i  ({req_type_i, req_host_i}),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .count_o      (q_count_o),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .entries_o    (fifo_entries),
    .entry_live_o (fifo_live)
  );

  // Request admission: urgent slot, heartbeat coalescing, FIFO push and drop flags.
  always_comb begin
    accept     = (state_q == SCH_OFFER) && msg_ready_i;
    fifo_pop   = accept && !from_slot_q;
    req_legal  = is_legal_type(req_type_i);
    req_logout = (req_type_i == MSG_LOGOUT);
    req_hb     = (req_type_i == MSG_HEARTBEAT);

    hb_dup = (state_q == SCH_OFFER) && !msg_ready_i &&
             (msg_type_q == MSG_HEARTBEAT) && (msg_host_q == req_host_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_live[i] && (fifo_entries[i][W-1:HOST_W] == MSG_HEARTBEAT) &&
          (fifo_entries[i][HOST_W-1:0] == req_host_i))
        hb_dup = 1'b1;
    end

    queue_req  = req_valid_i && req_legal && !req_logout && !(req_hb && hb_dup);
    fifo_push  = queue_req && (!fifo_full || fifo_pop);
    overflow_d = (queue_req && fifo_full && !fifo_pop) ||
                 (req_valid_i && req_logout && slot_full_q);
    illegal_d  = req_valid_i && !req_legal;

    slot_full_d = slot_full_q && !(accept && from_slot_q);
    slot_host_d = slot_host_q;
    if (req_valid_i && req_logout && !slot_full_q) begin
      slot_full_d = 1'b1;
      slot_host_d = req_host_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    msg_valid_d = msg_valid_q;
    msg_type_d  = msg_type_q;
    msg_host_d  = msg_host_q;
    from_slot_d = from_slot_q;
    timer_d     = timer_q;
    timeout_d   = 1'b0;
    case (state_q)
      SCH_IDLE: begin
        if (slot_full_q) begin
          msg_type_d  = MSG_LOGOUT;
          msg_host_d  = slot_host_q;
          from_slot_d = 1'b1;
          msg_valid_d = 1'b1;
          state_d     = SCH_OFFER;
        end else if (!fifo_empty) begin
          {msg_type_d, msg_host_d} = fifo_head;
          from_slot_d = 1'b0;
          msg_valid_d = 1'b1;
          state_d     = SCH_OFFER;
        end
      end
      SCH_OFFER: begin
        if (msg_ready_i) begin
          msg_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = SCH_BUSY;
        end
      end
      SCH_BUSY: begin
        if (creator_done_i) begin
          state_d = SCH_IDLE;
        end else if (timer_q == TW'(DONE_TO - 1)) begin
          timeout_d = 1'b1;
          state_d   = SCH_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SCH_IDLE;
      msg_valid_q <= 1'b0;
      msg_type_q  <= '0;
      msg_host_q  <= '0;
      from_slot_q <= 1'b0;
      timer_q     <= '0;
      slot_full_q <= 1'b0;
      slot_host_q <= '0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_valid_q <= msg_valid_d;
      msg_type_q  <= msg_type_d;
      msg_host_q  <= msg_host_d;
      from_slot_q <= from_slot_d;
      timer_q     <= timer_d;
      slot_full_q <= slot_full_d;
      slot_host_q <= slot_host_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
    end
  end

  assign msg_valid_o    = msg_valid_q;
  assign msg_type_o     = msg_type_q;
  assign msg_host_o     = msg_host_q;
  assign overflow_o     = overflow_q;
  assign illegal_o      = illegal_q;
  assign done_timeout_o = timeout_q;

endmodule
